npc_seq_ctrl: RTL and testbench
===============================

Name: npc_seq_ctrl

Overview:
Multi-cycle sequencer for the single-issue NPC core.
- Owns the architectural PC, the instruction register and the retired-instruction counter.
- Steps each instruction through fetch request, fetch wait, execute settle and writeback around the combinational decode/execute datapath.
- Drives the register-file write enable and the PC update from the execute unit's npc/wen_pc/wen_reg outputs.
- Stops the core on ebreak, illegal opcode, misaligned jump target or fetch timeout.

Parameters:
RESET_PC, 64'h8000_0000, PC value loaded on reset
FETCH_TIMEOUT, 255, max cycles spent in S_IF_WAIT without a response before halting (must be >= 1)

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  64  fetch address (equals pc)
imem_req_ready  in  1  memory accepts request
imem_resp_valid  in  1  fetch data valid
imem_resp_data  in  32  fetched instruction
inst  out  32  latched instruction to decoder/exu
pc  out  64  current PC to exu
exu_npc  in  64  next PC computed by exu
exu_wen_pc  in  1  exu requests PC redirect
exu_wen_reg  in  1  exu requests register write
rf_wen  out  1  register-file write strobe
halt  out  1  core stopped (sticky)
halt_cause  out  3  0 none, 1 ebreak, 2 illegal opcode, 3 fetch timeout, 4 misaligned target
instret  out  64  retired instruction count
state  out  3  FSM state for debug

Behaviour:
Reset (rst high at a clk edge):
- State registers: state=S_RESET, pc=RESET_PC, inst=32'h0000_0013, halt=0, halt_cause=0, instret=0, timeout counter=0.
- Outputs: imem_req_valid=0, rf_wen=0.
- rst mid-operation (any state, including HALT) aborts the current instruction; no rf_wen and no pc update on that edge.

States and encodings: S_RESET=0, S_IF_REQ=1, S_IF_WAIT=2, S_EX=3, S_WB=4, S_HALT=5.
- S_RESET: unconditional move to S_IF_REQ, giving one idle cycle after reset deassertion.
- S_IF_REQ: imem_req_valid=1, imem_req_addr=pc; both held stable until imem_req_ready=1. Handshake: move to S_IF_WAIT and clear the timeout counter.
- S_IF_WAIT:
  - imem_resp_valid is sampled only in this state; a response asserted in the handshake cycle itself is ignored.
  - On imem_resp_valid: inst <= imem_resp_data, then classify:
    - data == 32'h0010_0073: move to S_HALT, cause 1, instret+1.
    - opcode [6:0] not in {0010011, 0110111, 0010111, 1101111, 1100111}: move to S_HALT, cause 2, instret unchanged.
    - otherwise: move to S_EX.
  - No response: the counter increments each cycle. When the counter reaches FETCH_TIMEOUT: move to S_HALT, cause 3.
  - A response arriving in the same cycle the counter would reach FETCH_TIMEOUT wins.
- S_EX: one settle cycle for the combinational exu; no outputs change; move to S_WB.
- S_WB:
  - Target t = exu_wen_pc ? exu_npc : pc+4 (64-bit wrap).
  - If t[1:0] != 0: move to S_HALT, cause 4; rf_wen=0, pc unchanged, instret unchanged.
  - Else: rf_wen = exu_wen_reg & (inst[11:7] != 0) for this cycle only; pc <= t; instret+1; move to S_IF_REQ.
- S_HALT: sticky until rst. halt=1, imem_req_valid=0, rf_wen=0; pc and inst hold the faulting values.

Output timing:
- rf_wen and imem_req_valid are decoded combinationally from state (plus inputs for rf_wen); no other output is combinational.
- halt, halt_cause, instret, pc and inst are registered.

Latency and counter rules:
- Minimum latency is 4 cycles per instruction (IF_REQ, IF_WAIT, EX, WB) when ready/resp are both immediate.
- instret wraps at 2^64.

Test Plan:
- Reset, then imem_req_ready=1 with resp one cycle after the handshake, instruction addi x1,x0,5 (32'h0050_0093) -> imem_req_addr=0x8000_0000; rf_wen pulses for exactly one cycle 4 cycles after the first request; pc becomes 0x8000_0004; instret=1.
- jal x0,+16 (32'h0100_006F) with exu_wen_pc=1, exu_npc=0x8000_0010, exu_wen_reg=1 -> rf_wen stays 0 (rd=0); next imem_req_addr=0x8000_0010.
- Hold imem_req_ready=0 for 5 cycles -> imem_req_valid and imem_req_addr stay stable throughout; state stays 1; no counter movement.
- No response for FETCH_TIMEOUT=3 cycles -> halt=1, halt_cause=3, imem_req_valid=0 afterwards. Variant with a response in the 3rd cycle -> no halt.
- Fetch 32'h0010_0073 after 2 retired instructions -> halt=1, cause=1, instret=3. Fetch 32'h0000_0033 instead -> cause=2, instret=2.
- jalr with exu_npc=0x8000_0006 -> halt cause 4, rf_wen never asserted, pc unchanged. Assert rst while in S_HALT -> next cycle state=0, halt=0, pc=RESET_PC.

Source files
------------

// File: rtl/npc_seq_ctrl.sv
// Multi-cycle sequencer for the single-issue NPC core: fetch, wait, execute settle,
// writeback, with sticky halt on ebreak, illegal opcode, fetch timeout or misaligned target.
module npc_seq_ctrl #(
  parameter logic [63:0] RESET_PC      = 64'h8000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] inst,
  output logic [63:0] pc,
  input  logic [63:0] exu_npc,
  input  logic        exu_wen_pc,
  input  logic        exu_wen_reg,
  output logic        rf_wen,
  output logic        halt,
  output logic [2:0]  halt_cause,
  output logic [63:0] instret,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_IF_REQ  = 3'd1,
    S_IF_WAIT = 3'd2,
    S_EX      = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam int TW = $clog2(FETCH_TIMEOUT + 1);
  // Counter value seen in the last permitted wait cycle.
  localparam logic [TW-1:0] TO_LAST = TW'(FETCH_TIMEOUT - 1);

  state_t        cur, nxt;
  logic [TW-1:0] to_cnt;
  logic [63:0]   target;
  logic          misaligned, is_ebreak, is_legal, timed_out;

  assign target     = exu_wen_pc ? exu_npc : pc + 64'd4;
  assign misaligned = target[1:0] != 2'b00;
  assign is_ebreak  = imem_resp_data == EBREAK;
  assign timed_out  = to_cnt == TO_LAST;

  always_comb begin
    is_legal = 1'b0;
    case (imem_resp_data[6:0])
      7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cur <= S_RESET;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_RESET:   nxt = S_IF_REQ;
      S_IF_REQ:  if (imem_req_ready) nxt = S_IF_WAIT;
      S_IF_WAIT: begin
        if (imem_resp_valid) nxt = (is_ebreak || !is_legal) ? S_HALT : S_EX;
        else if (timed_out)  nxt = S_HALT;
      end
      S_EX:      nxt = S_WB;
      S_WB:      nxt = misaligned ? S_HALT : S_IF_REQ;
      S_HALT:    nxt = S_HALT;
      default:   nxt = S_RESET;
    endcase
  end

  // Reset gating keeps an aborted writeback or fetch from leaking out on the reset edge.
  always_comb begin
    imem_req_valid = !rst && (cur == S_IF_REQ);
    rf_wen         = !rst && (cur == S_WB) && !misaligned && exu_wen_reg && (inst[11:7] != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      inst       <= 32'h0000_0013;
      halt       <= 1'b0;
      halt_cause <= 3'd0;
      instret    <= 64'd0;
      to_cnt     <= '0;
    end else begin
      case (cur)
        S_IF_REQ: if (imem_req_ready) to_cnt <= '0;
        S_IF_WAIT: begin
          if (imem_resp_valid) begin
            inst <= imem_resp_data;
            if (is_ebreak) begin
              halt       <= 1'b1;
              halt_cause <= 3'd1;
              instret    <= instret + 64'd1;
            end else if (!is_legal) begin
              halt       <= 1'b1;
              halt_cause <= 3'd2;
            end
          end else if (timed_out) begin
            halt       <= 1'b1;
            halt_cause <= 3'd3;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_WB: begin
          if (misaligned) begin
            halt       <= 1'b1;
            halt_cause <= 3'd4;
          end else begin
            pc      <= target;
            instret <= instret + 64'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req_addr = pc;
  assign state         = cur;

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Scoreboarded bench for npc_seq_ctrl: tasks act as imem and exu, a reference model
// queues expected fetch addresses and register writes, a negedge monitor checks them.
module tb_npc_seq_ctrl;
  localparam logic [63:0] RPC    = 64'h8000_0000;
  localparam int          FT     = 3;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [63:0] imem_req_addr, pc, exu_npc, instret;
  logic [31:0] imem_resp_data, inst;
  logic        exu_wen_pc, exu_wen_reg, rf_wen, halt;
  logic [2:0]  halt_cause, state;

  npc_seq_ctrl #(.RESET_PC(RPC), .FETCH_TIMEOUT(FT)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst(inst), .pc(pc),
    .exu_npc(exu_npc), .exu_wen_pc(exu_wen_pc), .exu_wen_reg(exu_wen_reg),
    .rf_wen(rf_wen), .halt(halt), .halt_cause(halt_cause), .instret(instret), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; logic [4:0] rd; } wb_t;
  logic [63:0] addr_q[$];
  wb_t         wb_q[$];
  int tests = 0, fails = 0, cyc = 0, req_cyc = 0, wb_cyc = 0;

  // Architectural model state
  logic [63:0] m_pc, m_instret;
  logic [31:0] m_inst;
  logic        m_halt;
  logic [2:0]  m_cause;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (imem_req_valid) begin
      if (addr_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_req: addr %h with no fetch expected", imem_req_addr);
      end else begin
        chk("req_addr", imem_req_addr, addr_q[0]);
        chk("req_state", state, 64'd1);
        if (imem_req_ready) begin
          void'(addr_q.pop_front());
          req_cyc = cyc;
        end
      end
    end
    if (rf_wen) begin
      wb_cyc = cyc;
      if (wb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_rf_wen: pc %h rd %0d", pc, inst[11:7]);
      end else begin
        chk("wb_pc", pc, wb_q[0].pc);
        chk("wb_rd", inst[11:7], wb_q[0].rd);
        void'(wb_q.pop_front());
      end
    end
    if (halt) begin
      chk("halt_req_valid", imem_req_valid, 64'd0);
      chk("halt_rf_wen", rf_wen, 64'd0);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    exu_wen_pc = 1'b0; exu_wen_reg = 1'b0;
    step();
    chk("wb_drained", wb_q.size(), 64'd0);
    chk("addr_drained", addr_q.size(), 64'd0);
    addr_q.delete(); wb_q.delete();
    chk("rst_state", state, 64'd0);
    chk("rst_pc", pc, RPC);
    chk("rst_inst", inst, 64'h13);
    chk("rst_halt", halt, 64'd0);
    chk("rst_cause", halt_cause, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_req_valid", imem_req_valid, 64'd0);
    chk("rst_rf_wen", rf_wen, 64'd0);
    rst = 1'b0;
    m_pc = RPC; m_instret = 64'd0; m_inst = 32'h13; m_halt = 1'b0; m_cause = 3'd0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req_valid && n < 20) begin step(); n++; end
    chk("req_wait", imem_req_valid, 64'd1);
  endtask

  // Architectural effect of one fetched instruction.
  task automatic model(input logic [31:0] ins, input logic wpc, input logic [63:0] npc, input logic wreg);
    logic [63:0] t;
    m_inst = ins;
    if (ins == EBREAK) begin
      m_instret++; m_halt = 1'b1; m_cause = 3'd1;
    end else if (!(ins[6:0] inside {7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111})) begin
      m_halt = 1'b1; m_cause = 3'd2;
    end else begin
      t = wpc ? npc : m_pc + 64'd4;
      if (t[1:0] != 2'b00) begin
        m_halt = 1'b1; m_cause = 3'd4;
      end else begin
        if (wreg && ins[11:7] != 5'd0) wb_q.push_back('{pc: m_pc, rd: ins[11:7]});
        m_pc = t; m_instret++;
      end
    end
  endtask

  task automatic run_inst(input logic [31:0] ins, input logic wpc, input logic [63:0] npc,
                          input logic wreg, input int rdly, input int sdly, input logic junk);
    int n = 0;
    addr_q.push_back(m_pc);
    wait_req();
    repeat (rdly) begin
      imem_req_ready = 1'b0; imem_resp_valid = junk; imem_resp_data = 32'h0; step();
    end
    imem_req_ready = 1'b1; imem_resp_valid = junk; imem_resp_data = 32'h0; step();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    exu_wen_pc = wpc; exu_npc = npc; exu_wen_reg = wreg;
    repeat (sdly) step();
    imem_resp_valid = 1'b1; imem_resp_data = ins; step();
    imem_resp_valid = 1'b0; imem_resp_data = $urandom();
    model(ins, wpc, npc, wreg);
    while (!imem_req_valid && !halt && n < 20) begin step(); n++; end
    chk("inst_done_late", n >= 20, 64'd0);
    chk("pc", pc, m_pc);
    chk("instret", instret, m_instret);
    chk("inst", inst, m_inst);
    chk("halt", halt, m_halt);
    chk("halt_cause", halt_cause, m_cause);
  endtask

  task automatic run_timeout();
    int n = 0;
    addr_q.push_back(m_pc);
    wait_req();
    imem_req_ready = 1'b1; step();
    imem_req_ready = 1'b0;
    while (!halt && n < 10) begin step(); n++; end
    chk("timeout_cycles", n, FT);
    m_halt = 1'b1; m_cause = 3'd3;
    chk("to_halt", halt, 64'd1);
    chk("to_cause", halt_cause, 64'd3);
    repeat (3) step();
    chk("to_req_valid", imem_req_valid, 64'd0);
    chk("to_state", state, 64'd5);
    chk("to_pc", pc, m_pc);
  endtask

  task automatic rand_inst(input logic allow_jump);
    logic [6:0]  ops[5] = '{7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    logic [31:0] r = $urandom();
    logic [31:0] ins;
    logic [63:0] npc = {$urandom(), $urandom()};
    logic        wpc = allow_jump && ($urandom_range(0, 1) == 1);
    ins = {r[31:12], 5'($urandom_range(0, 31)), ops[$urandom_range(0, 4)]};
    npc[1:0] = 2'b00;
    run_inst(ins, wpc, npc, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             $urandom_range(0, FT - 1), 1'($urandom_range(0, 3) == 0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    exu_npc = 64'h0; exu_wen_pc = 1'b0; exu_wen_reg = 1'b0;

    // Directed: addi, jal x0, long ready stall, then ebreak.
    do_reset();
    run_inst(32'h0050_0093, 1'b0, 64'h0, 1'b1, 0, 1, 1'b0);
    chk("first_latency", 64'(wb_cyc - req_cyc), 64'd4);
    chk("addi_pc", pc, 64'h8000_0004);
    chk("addi_instret", instret, 64'd1);
    run_inst(32'h0100_006F, 1'b1, 64'h8000_0010, 1'b1, 0, 0, 1'b0);
    chk("jal_pc", pc, 64'h8000_0010);
    run_inst(32'h0001_22B7, 1'b0, 64'h0, 1'b1, 5, FT - 1, 1'b1);
    run_inst(EBREAK, 1'b0, 64'h0, 1'b0, 0, 0, 1'b0);

    // Fetch timeout.
    do_reset();
    run_inst(32'h0050_0093, 1'b0, 64'h0, 1'b1, 0, 0, 1'b0);
    run_timeout();

    // ebreak after two retired instructions.
    do_reset();
    rand_inst(1'b0); rand_inst(1'b0);
    run_inst(EBREAK, 1'b0, 64'h0, 1'b0, 1, 1, 1'b0);
    chk("ebreak_cause", halt_cause, 64'd1);
    chk("ebreak_instret", instret, 64'd3);

    // Illegal opcode after two retired instructions.
    do_reset();
    rand_inst(1'b0); rand_inst(1'b0);
    run_inst(32'h0000_0033, 1'b0, 64'h0, 1'b1, 0, 2, 1'b0);
    chk("illegal_cause", halt_cause, 64'd2);
    chk("illegal_instret", instret, 64'd2);

    // Misaligned jalr target, then reset out of halt.
    do_reset();
    run_inst(32'h0000_80E7, 1'b1, 64'h8000_0006, 1'b1, 0, 0, 1'b0);
    chk("misalign_cause", halt_cause, 64'd4);
    chk("misalign_pc", pc, RPC);
    do_reset();

    // Randomized program.
    for (int i = 0; i < 40; i++) rand_inst(1'b1);
    run_inst(EBREAK, 1'b0, 64'h0, 1'b0, 0, 0, 1'b0);
    chk("final_wb_drained", wb_q.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
